// File: rtl/uart_rx_module.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_module
// Purpose  : UART receiver running on a pre-divided baud clock (one clock
//            period per bit). The serial line is brought into the clock
//            domain by a two-flop synchronizer. A four-state FSM
//            (IDLE/DATA/PARITY/STOP) deserialises one frame and delivers it
//            as a single-cycle valid pulse with parity and framing flags.
// Ports    : i_clk           - baud-rate clock, one edge per serial bit
//            i_rst           - synchronous active-high reset
//            i_uart_rx       - asynchronous serial input, idle high
//            o_user_rx_data  - received word, LSB = first data bit on line
//            o_user_rx_valid - one-cycle pulse per received frame
//            o_parity_err    - parity mismatch, qualified by valid
//            o_frame_err     - a stop bit was sampled low, qualified by valid
// Revision : 1.0 - initial release
// ============================================================================
module uart_rx_module #(
    parameter int P_DATA_WIDTH = 8,  // data bits per frame, 5..8
    parameter int P_PARITY     = 0,  // 0 none, 1 odd, 2 even
    parameter int P_STOP_WIDTH = 1   // stop bits per frame, 1 or 2
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_uart_rx,
    output logic [P_DATA_WIDTH-1:0] o_user_rx_data,
    output logic                    o_user_rx_valid,
    output logic                    o_parity_err,
    output logic                    o_frame_err
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam int                 c_CNT_W      = 4;
    localparam logic [c_CNT_W-1:0] c_LAST_DATA  = c_CNT_W'(P_DATA_WIDTH - 1);
    localparam logic [c_CNT_W-1:0] c_LAST_STOP  = c_CNT_W'(P_STOP_WIDTH - 1);
    localparam bit                 c_HAS_PARITY = (P_PARITY != 0);
    localparam bit                 c_ODD_PARITY = (P_PARITY == 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_PARITY = 2'd2,
        ST_STOP   = 2'd3
    } state_t;

    // ------------------------------------------------------------------------
    // Registers and next-state values
    // ------------------------------------------------------------------------
    logic                    sync1_q;
    logic                    rx_s_q;

    state_t                  state_q,     state_d;
    logic [c_CNT_W-1:0]      cnt_q,       cnt_d;
    logic [P_DATA_WIDTH-1:0] shift_q,     shift_d;
    logic                    par_bit_q,   par_bit_d;
    logic                    ferr_q,      ferr_d;

    logic [P_DATA_WIDTH-1:0] data_q,      data_d;
    logic                    valid_q,     valid_d;
    logic                    perr_q,      perr_d;
    logic                    frame_err_q, frame_err_d;

    logic                    w_par_expected;
    logic                    w_par_bad;
    logic                    w_ferr_now;

    // Expected parity bit: even parity makes the total count of ones even,
    // so the bit equals the XOR of the data; odd parity is its inverse.
    assign w_par_expected = c_ODD_PARITY ? ~(^shift_q) : (^shift_q);
    assign w_par_bad      = c_HAS_PARITY && (par_bit_q != w_par_expected);

    // ------------------------------------------------------------------------
    // State register, synchronizer and output registers
    // ------------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            // Synchronizer flops reset to the idle line level so that
            // leaving reset never looks like a start bit.
            sync1_q     <= 1'b1;
            rx_s_q      <= 1'b1;
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            shift_q     <= '0;
            par_bit_q   <= 1'b0;
            ferr_q      <= 1'b0;
            data_q      <= '0;
            valid_q     <= 1'b0;
            perr_q      <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            sync1_q     <= i_uart_rx;
            rx_s_q      <= sync1_q;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            shift_q     <= shift_d;
            par_bit_q   <= par_bit_d;
            ferr_q      <= ferr_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
            perr_q      <= perr_d;
            frame_err_q <= frame_err_d;
        end
    end

    // ------------------------------------------------------------------------
    // Next-state and output logic
    // ------------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        shift_d     = shift_q;
        par_bit_d   = par_bit_q;
        ferr_d      = ferr_q;
        data_d      = data_q;     // data word holds between frames
        valid_d     = 1'b0;       // valid and flags default low: pulses only
        perr_d      = 1'b0;
        frame_err_d = 1'b0;
        // Frame error including the stop bit sampled at this edge.
        w_ferr_now  = ferr_q | ~rx_s_q;

        case (state_q)
            ST_IDLE: begin
                // Any low sample is a start bit; it is consumed here.
                if (!rx_s_q) begin
                    state_d = ST_DATA;
                    cnt_d   = '0;
                    ferr_d  = 1'b0;
                end
            end

            ST_DATA: begin
                // Shift in from the top so the first bit ends up at the LSB.
                shift_d = {rx_s_q, shift_q[P_DATA_WIDTH-1:1]};
                if (cnt_q == c_LAST_DATA) begin
                    cnt_d   = '0;
                    state_d = c_HAS_PARITY ? ST_PARITY : ST_STOP;
                end else begin
                    cnt_d = cnt_q + c_CNT_W'(1);
                end
            end

            ST_PARITY: begin
                par_bit_d = rx_s_q;
                cnt_d     = '0;
                state_d   = ST_STOP;
            end

            ST_STOP: begin
                ferr_d = w_ferr_now;
                if (cnt_q == c_LAST_STOP) begin
                    state_d     = ST_IDLE;
                    cnt_d       = '0;
                    data_d      = shift_q;
                    valid_d     = 1'b1;
                    perr_d      = w_par_bad;
                    frame_err_d = w_ferr_now;
                end else begin
                    cnt_d = cnt_q + c_CNT_W'(1);
                end
            end

            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign o_user_rx_data  = data_q;
    assign o_user_rx_valid = valid_q;
    assign o_parity_err    = perr_q;
    assign o_frame_err     = frame_err_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_module.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_rx_module
// Purpose  : Self-checking bench for uart_rx_module. Four receivers with
//            different frame formats (8N1, 8E1, 8N2, 5O2) each get their own
//            serial line. A frame-level model predicts, for every frame sent,
//            the cycle of the valid pulse, the data word and both flags.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_uart_rx_module;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst = 1'b1;
    logic rx [4];

    wire [7:0] dat [4];
    wire [4:0] dat3;
    wire       vld [4];
    wire       per [4];
    wire       fer [4];

    assign dat[3] = {3'b000, dat3};

    uart_rx_module #(.P_DATA_WIDTH(8), .P_PARITY(0), .P_STOP_WIDTH(1)) u_dut0 (
        .i_clk(clk), .i_rst(rst), .i_uart_rx(rx[0]), .o_user_rx_data(dat[0]),
        .o_user_rx_valid(vld[0]), .o_parity_err(per[0]), .o_frame_err(fer[0]));
    uart_rx_module #(.P_DATA_WIDTH(8), .P_PARITY(2), .P_STOP_WIDTH(1)) u_dut1 (
        .i_clk(clk), .i_rst(rst), .i_uart_rx(rx[1]), .o_user_rx_data(dat[1]),
        .o_user_rx_valid(vld[1]), .o_parity_err(per[1]), .o_frame_err(fer[1]));
    uart_rx_module #(.P_DATA_WIDTH(8), .P_PARITY(0), .P_STOP_WIDTH(2)) u_dut2 (
        .i_clk(clk), .i_rst(rst), .i_uart_rx(rx[2]), .o_user_rx_data(dat[2]),
        .o_user_rx_valid(vld[2]), .o_parity_err(per[2]), .o_frame_err(fer[2]));
    uart_rx_module #(.P_DATA_WIDTH(5), .P_PARITY(1), .P_STOP_WIDTH(2)) u_dut3 (
        .i_clk(clk), .i_rst(rst), .i_uart_rx(rx[3]), .o_user_rx_data(dat3),
        .o_user_rx_valid(vld[3]), .o_parity_err(per[3]), .o_frame_err(fer[3]));

    // Frame format of each receiver
    function automatic int cfg_w(input int d);
        return (d == 3) ? 5 : 8;
    endfunction
    function automatic int cfg_p(input int d);
        return (d == 1) ? 2 : ((d == 3) ? 1 : 0);
    endfunction
    function automatic int cfg_s(input int d);
        return (d >= 2) ? 2 : 1;
    endfunction

    typedef struct {
        int         dut;
        int         cyc;
        logic [7:0] data;
        logic       perr;
        logic       ferr;
    } ev_t;

    ev_t got_q[$];
    ev_t exp_q[$];

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    logic rst_edge = 1'b1;
    logic [7:0] prev_dat [4];

    always @(posedge clk) begin
        cyc      <= cyc + 1;
        rst_edge <= rst;
    end

    // Monitor: log every valid pulse; between pulses flags must be low and
    // the data word must not move (except when reset clears it).
    always @(negedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (vld[i] === 1'b1) begin
                ev_t e;
                e.dut = i; e.cyc = cyc; e.data = dat[i];
                e.perr = per[i]; e.ferr = fer[i];
                got_q.push_back(e);
            end else begin
                total++;
                if ((per[i] | fer[i]) !== 1'b0) begin
                    bad++;
                    $display("FAIL flags_idle dut%0d cyc=%0d got perr=%b ferr=%b want 0 0",
                             i, cyc, per[i], fer[i]);
                end
                if (!rst_edge) begin
                    total++;
                    if (dat[i] !== prev_dat[i]) begin
                        bad++;
                        $display("FAIL data_hold dut%0d cyc=%0d got %h want %h",
                                 i, cyc, dat[i], prev_dat[i]);
                    end
                end
            end
            prev_dat[i] = dat[i];
        end
    end

    // Reference model: build the bit sequence of one frame and predict the
    // delivered event. Start bit first sampled at E0 = next edge; the pulse
    // appears at E0 + frame_length + 1.
    task automatic send_frame(input int d, input logic [7:0] data,
                              input bit flip, input logic [1:0] stops);
        int         w = cfg_w(d);
        int         p = cfg_p(d);
        int         s = cfg_s(d);
        logic [7:0] m;
        logic [7:0] mask;
        bit         par;
        bit         bits[$];
        ev_t        e;
        mask = 8'((1 << w) - 1);
        m    = data & mask;
        bits.push_back(1'b0);
        for (int i = 0; i < w; i++) bits.push_back(m[i]);
        par = ($countones(m) % 2) == 1;       // even-parity bit
        if (p == 1) par = !par;
        if (p != 0) bits.push_back(par ^ flip);
        e.ferr = 1'b0;
        for (int i = 0; i < s; i++) begin
            bits.push_back(stops[i]);
            if (!stops[i]) e.ferr = 1'b1;
        end
        e.dut  = d;
        e.cyc  = cyc + 2 + bits.size();
        e.data = m;
        e.perr = (p != 0) && flip;
        exp_q.push_back(e);
        foreach (bits[i]) begin
            rx[d] = bits[i];
            @(negedge clk);
        end
    endtask

    task automatic idle(input int d, input int n);
        rx[d] = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    // Bounded wait for all predicted frames, then some slack for strays.
    task automatic drain(input int budget);
        int n = 0;
        for (int i = 0; i < 4; i++) rx[i] = 1'b1;
        while (got_q.size() < exp_q.size() && n < budget) begin
            @(negedge clk);
            n++;
        end
        repeat (15) @(negedge clk);
    endtask

    task automatic clear_q();
        got_q.delete();
        exp_q.delete();
    endtask

    // ------------------------------------------------------------------------
    task automatic test_reset();
        for (int i = 0; i < 4; i++) rx[i] = 1'b1;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            total++;
            if (vld[i] !== 1'b0 || per[i] !== 1'b0 || fer[i] !== 1'b0 || dat[i] !== 8'h00) begin
                bad++;
                $display("FAIL reset_state dut%0d got v=%b p=%b f=%b d=%h want 0 0 0 00",
                         i, vld[i], per[i], fer[i], dat[i]);
            end
        end
        rst = 1'b0;
        clear_q();
        repeat (25) @(negedge clk);
        total++;
        if (got_q.size() != 0) begin
            bad++;
            $display("FAIL reset_no_frame got %0d pulses want 0", got_q.size());
        end
    endtask

    task automatic test_basic();
        clear_q();
        idle(0, 3);
        send_frame(0, 8'hA5, 1'b0, 2'b11);
        idle(0, 2);
        for (int k = 0; k < 6; k++) begin
            send_frame(0, 8'($urandom_range(255)), 1'b0, 2'b11);
            idle(0, $urandom_range(3));
        end
        drain(200);
        total++;
        if (got_q.size() != exp_q.size()) begin
            bad++;
            $display("FAIL basic_count got %0d want %0d", got_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            total++;
            if (got_q[i].dut != exp_q[i].dut || got_q[i].cyc != exp_q[i].cyc ||
                got_q[i].data !== exp_q[i].data || got_q[i].perr !== exp_q[i].perr ||
                got_q[i].ferr !== exp_q[i].ferr) begin
                bad++;
                $display("FAIL basic_frame%0d got dut%0d cyc=%0d d=%h p=%b f=%b want dut%0d cyc=%0d d=%h p=%b f=%b",
                         i, got_q[i].dut, got_q[i].cyc, got_q[i].data, got_q[i].perr, got_q[i].ferr,
                         exp_q[i].dut, exp_q[i].cyc, exp_q[i].data, exp_q[i].perr, exp_q[i].ferr);
            end
        end
    endtask

    task automatic test_parity();
        clear_q();
        send_frame(1, 8'h03, 1'b1, 2'b11);   // parity bit 1 on even parity: error
        idle(1, 2);
        send_frame(1, 8'h03, 1'b0, 2'b11);   // parity bit 0: clean
        idle(1, 2);
        for (int k = 0; k < 10; k++) begin
            int d = (k % 2 == 0) ? 1 : 3;
            logic [1:0] st = ($urandom_range(3) == 0) ? 2'($urandom_range(3)) : 2'b11;
            send_frame(d, 8'($urandom_range(255)), 1'($urandom_range(1)), st);
            idle(d, $urandom_range(2));
        end
        drain(300);
        total++;
        if (got_q.size() != exp_q.size()) begin
            bad++;
            $display("FAIL parity_count got %0d want %0d", got_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            total++;
            if (got_q[i].dut != exp_q[i].dut || got_q[i].cyc != exp_q[i].cyc ||
                got_q[i].data !== exp_q[i].data || got_q[i].perr !== exp_q[i].perr ||
                got_q[i].ferr !== exp_q[i].ferr) begin
                bad++;
                $display("FAIL parity_frame%0d got dut%0d cyc=%0d d=%h p=%b f=%b want dut%0d cyc=%0d d=%h p=%b f=%b",
                         i, got_q[i].dut, got_q[i].cyc, got_q[i].data, got_q[i].perr, got_q[i].ferr,
                         exp_q[i].dut, exp_q[i].cyc, exp_q[i].data, exp_q[i].perr, exp_q[i].ferr);
            end
        end
    endtask

    task automatic test_frame_err();
        clear_q();
        send_frame(0, 8'h3C, 1'b0, 2'b00);   // stop bit low
        send_frame(0, 8'h55, 1'b0, 2'b11);
        idle(0, 2);
        send_frame(2, 8'hC3, 1'b0, 2'b01);   // second stop bit low
        idle(2, 2);
        send_frame(2, 8'h69, 1'b0, 2'b10);   // first stop bit low
        idle(2, 2);
        send_frame(2, 8'h96, 1'b0, 2'b11);
        drain(200);
        total++;
        if (got_q.size() != exp_q.size()) begin
            bad++;
            $display("FAIL frame_err_count got %0d want %0d", got_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            total++;
            if (got_q[i].dut != exp_q[i].dut || got_q[i].cyc != exp_q[i].cyc ||
                got_q[i].data !== exp_q[i].data || got_q[i].perr !== exp_q[i].perr ||
                got_q[i].ferr !== exp_q[i].ferr) begin
                bad++;
                $display("FAIL frame_err_frame%0d got dut%0d cyc=%0d d=%h p=%b f=%b want dut%0d cyc=%0d d=%h p=%b f=%b",
                         i, got_q[i].dut, got_q[i].cyc, got_q[i].data, got_q[i].perr, got_q[i].ferr,
                         exp_q[i].dut, exp_q[i].cyc, exp_q[i].data, exp_q[i].perr, exp_q[i].ferr);
            end
        end
    endtask

    task automatic test_back_to_back();
        clear_q();
        send_frame(0, 8'h01, 1'b0, 2'b11);
        send_frame(0, 8'h80, 1'b0, 2'b11);
        send_frame(0, 8'hFF, 1'b0, 2'b11);
        drain(100);
        total++;
        if (got_q.size() != 3) begin
            bad++;
            $display("FAIL b2b_count got %0d want 3", got_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            total++;
            if (got_q[i].dut != exp_q[i].dut || got_q[i].cyc != exp_q[i].cyc ||
                got_q[i].data !== exp_q[i].data || got_q[i].perr !== exp_q[i].perr ||
                got_q[i].ferr !== exp_q[i].ferr) begin
                bad++;
                $display("FAIL b2b_frame%0d got dut%0d cyc=%0d d=%h p=%b f=%b want dut%0d cyc=%0d d=%h p=%b f=%b",
                         i, got_q[i].dut, got_q[i].cyc, got_q[i].data, got_q[i].perr, got_q[i].ferr,
                         exp_q[i].dut, exp_q[i].cyc, exp_q[i].data, exp_q[i].perr, exp_q[i].ferr);
            end
        end
        if (got_q.size() == 3) begin
            total++;
            if (got_q[1].cyc - got_q[0].cyc != 10 || got_q[2].cyc - got_q[1].cyc != 10) begin
                bad++;
                $display("FAIL b2b_spacing got %0d %0d want 10 10",
                         got_q[1].cyc - got_q[0].cyc, got_q[2].cyc - got_q[1].cyc);
            end
        end
    endtask

    task automatic test_reset_midframe();
        logic [7:0] v;
        clear_q();
        // Abort a frame with a one-cycle reset after data bit 4.
        v = 8'($urandom_range(255));
        rx[0] = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            rx[0] = v[i];
            @(negedge clk);
        end
        rx[0] = 1'b1;
        rst   = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        total++;
        if (got_q.size() != 0 || dat[0] !== 8'h00 || per[0] !== 1'b0 || fer[0] !== 1'b0) begin
            bad++;
            $display("FAIL midframe_abort got pulses=%0d d=%h p=%b f=%b want 0 00 0 0",
                     got_q.size(), dat[0], per[0], fer[0]);
        end
        // Reset coincident with the last stop-bit sample (E0 + 11).
        clear_q();
        fork
            send_frame(0, 8'h77, 1'b0, 2'b11);
            begin
                repeat (11) @(negedge clk);
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
            end
        join
        exp_q.delete();
        repeat (20) @(negedge clk);
        total++;
        if (got_q.size() != 0 || dat[0] !== 8'h00) begin
            bad++;
            $display("FAIL reset_vs_stop got pulses=%0d d=%h want 0 00", got_q.size(), dat[0]);
        end
        // Reception resumes normally.
        clear_q();
        send_frame(0, 8'h5A, 1'b0, 2'b11);
        drain(50);
        total++;
        if (got_q.size() != 1) begin
            bad++;
            $display("FAIL after_reset_count got %0d want 1", got_q.size());
        end else begin
            total++;
            if (got_q[0].cyc != exp_q[0].cyc || got_q[0].data !== 8'h5A ||
                got_q[0].perr !== 1'b0 || got_q[0].ferr !== 1'b0) begin
                bad++;
                $display("FAIL after_reset_frame got cyc=%0d d=%h p=%b f=%b want cyc=%0d d=5a p=0 f=0",
                         got_q[0].cyc, got_q[0].data, got_q[0].perr, got_q[0].ferr, exp_q[0].cyc);
            end
        end
    endtask

    task automatic test_line_low();
        int e0;
        clear_q();
        idle(0, 2);
        // 30 low bit periods read as three 10-bit frames of zeros whose stop
        // bit is low.
        e0 = cyc + 1;
        rx[0] = 1'b0;
        repeat (30) @(negedge clk);
        rx[0] = 1'b1;
        for (int k = 0; k < 3; k++) begin
            ev_t e;
            e.dut = 0; e.cyc = e0 + 11 + 10 * k; e.data = 8'h00;
            e.perr = 1'b0; e.ferr = 1'b1;
            exp_q.push_back(e);
        end
        drain(60);
        total++;
        if (got_q.size() != exp_q.size()) begin
            bad++;
            $display("FAIL line_low_count got %0d want %0d", got_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            total++;
            if (got_q[i].cyc != exp_q[i].cyc || got_q[i].data !== exp_q[i].data ||
                got_q[i].perr !== exp_q[i].perr || got_q[i].ferr !== exp_q[i].ferr) begin
                bad++;
                $display("FAIL line_low_frame%0d got cyc=%0d d=%h p=%b f=%b want cyc=%0d d=%h p=%b f=%b",
                         i, got_q[i].cyc, got_q[i].data, got_q[i].perr, got_q[i].ferr,
                         exp_q[i].cyc, exp_q[i].data, exp_q[i].perr, exp_q[i].ferr);
            end
        end
    endtask

    // ------------------------------------------------------------------------
    initial begin
        for (int i = 0; i < 4; i++) rx[i] = 1'b1;
        @(negedge clk);
        test_reset();
        test_basic();
        test_parity();
        test_frame_err();
        test_back_to_back();
        test_reset_midframe();
        test_line_low();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
